// File: rtl/grp_idx_sched_if.sv
// Bundle between the group-index scheduler, its run controller, the channel
// source and the downstream group-index generator.
interface grp_idx_sched_if;
  logic        start;
  logic [15:0] num_ch;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        gen_valid;
  logic [15:0] gen_data;
  logic [15:0] gen_chidx;
  logic [15:0] gen_tmax;
  logic        ret_valid;
  logic [7:0]  ret_grp;
  logic        busy;
  logic        done;
  logic [7:0]  max_grp;

  modport master (
    output start, num_ch, in_valid, in_data, ret_valid, ret_grp,
    input  in_ready, gen_valid, gen_data, gen_chidx, gen_tmax, busy, done, max_grp
  );

  modport slave (
    input  start, num_ch, in_valid, in_data, ret_valid, ret_grp,
    output in_ready, gen_valid, gen_data, gen_chidx, gen_tmax, busy, done, max_grp
  );
endinterface

// File: rtl/grp_idx_sched.sv
// Two-phase group-index scheduler: buffers per-channel FP16 abs-max values while
// tracking Tmax, then streams them to the generator and collects its results.
//
// state   | meaning
// IDLE    | waiting for start; n=0 runs complete here
// LOAD    | accepting channel values into the buffer, tracking Tmax
// ISSUE   | one buffered channel per cycle to the generator
// DRAIN   | waiting for the remaining generator results
module grp_idx_sched #(
  parameter int NUM_CH = 64,
  parameter int AW     = $clog2(NUM_CH)
) (
  input logic             clk,
  input logic             rst,
  grp_idx_sched_if.slave  bus
);

  localparam int CW = $clog2(NUM_CH + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] n_q;
  logic [CW-1:0] wr_cnt;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] ret_cnt;
  logic [14:0]   tmax;
  logic          zero_pend;

  logic [14:0]   mem [NUM_CH];

  logic [CW-1:0] n_clamp;
  logic [CW-1:0] ret_cnt_nxt;
  logic          beat;
  logic          ret_take;
  logic          unused_sign;

  assign unused_sign  = bus.in_data[15];
  assign bus.in_ready = (state == S_LOAD);
  assign bus.busy     = (state != S_IDLE);
  assign bus.gen_tmax = {1'b0, tmax};

  assign beat        = bus.in_valid & (state == S_LOAD);
  // Results are only meaningful once issue has begun; the generator's
  // valid_out is not reset and may be high while we idle or load.
  assign ret_take    = bus.ret_valid & ((state == S_ISSUE) | (state == S_DRAIN));
  assign ret_cnt_nxt = ret_cnt + CW'(ret_take);

  always_comb begin
    n_clamp = bus.num_ch[CW-1:0];
    if (bus.num_ch > 16'(NUM_CH)) begin
      n_clamp = CW'(NUM_CH);
    end
  end

  always_ff @(posedge clk) begin
    if (beat) begin
      mem[wr_cnt[AW-1:0]] <= bus.in_data[14:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      n_q           <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      ret_cnt       <= '0;
      tmax          <= '0;
      zero_pend     <= 1'b0;
      bus.gen_valid <= 1'b0;
      bus.gen_data  <= '0;
      bus.gen_chidx <= '0;
      bus.done      <= 1'b0;
      bus.max_grp   <= '0;
    end else begin
      bus.done  <= 1'b0;
      zero_pend <= 1'b0;

      if (ret_take) begin
        ret_cnt <= ret_cnt_nxt;
        if (bus.ret_grp > bus.max_grp) begin
          bus.max_grp <= bus.ret_grp;
        end
      end

      case (state)
        S_IDLE: begin
          if (zero_pend) begin
            bus.done <= 1'b1;
          end
          if (bus.start) begin
            n_q         <= n_clamp;
            tmax        <= '0;
            bus.max_grp <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            ret_cnt     <= '0;
            if (n_clamp == '0) begin
              zero_pend <= 1'b1;
            end else begin
              state <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (beat) begin
            wr_cnt <= wr_cnt + 1'b1;
            // Unsigned compare of the magnitude bits orders non-negative FP16.
            if (bus.in_data[14:0] > tmax) begin
              tmax <= bus.in_data[14:0];
            end
            if (wr_cnt + 1'b1 == n_q) begin
              state <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          bus.gen_valid <= 1'b1;
          bus.gen_data  <= {1'b0, mem[rd_cnt[AW-1:0]]};
          bus.gen_chidx <= 16'(rd_cnt);
          rd_cnt        <= rd_cnt + 1'b1;
          if (rd_cnt == n_q - 1'b1) begin
            state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          bus.gen_valid <= 1'b0;
          if (ret_cnt_nxt == n_q) begin
            state    <= S_IDLE;
            bus.done <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grp_idx_sched.sv
// Bench for grp_idx_sched: a one-cycle generator stand-in plus a run-level
// timeline model derived from the accepted-beat edge and the channel count.
module tb_grp_idx_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  grp_idx_sched_if bus ();

  grp_idx_sched #(.NUM_CH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic        stray_en = 1'b0;
  int          run_id   = 0;
  int          seen_id  = 0;
  int          gen_max  = 0;
  int          g_val;
  logic [15:0] vals[$];
  int          pat[$];
  int          last_k;
  int          last_done_e;

  // Generator stand-in: one-cycle latency, random group index per channel.
  // Stray beats carry 0xFF so that any wrongly counted stray shows up in max_grp.
  always @(posedge clk) begin
    if (run_id != seen_id) begin
      seen_id = run_id;
      gen_max = 0;
    end
    if (bus.gen_valid === 1'b1) begin
      g_val = $urandom_range(0, 200);
      if (g_val > gen_max) gen_max = g_val;
      bus.ret_valid <= 1'b1;
      bus.ret_grp   <= 8'(g_val);
    end else if (stray_en) begin
      bus.ret_valid <= 1'b1;
      bus.ret_grp   <= 8'hFF;
    end else begin
      bus.ret_valid <= 1'b0;
      bus.ret_grp   <= 8'($urandom);
    end
  end

  task automatic drive_run(input int req, input int gap_pct, input bit stray,
                           input bit mid_start, input int abort_ch);
    int n, acc, k, e, done_e, ch;
    bit v, gv_exp;
    logic [14:0] tm;
    logic [15:0] d;
    n = (req > 64) ? 64 : req;
    while (vals.size() < n) vals.push_back(16'($urandom));
    tm = '0;
    for (int i = 0; i < n; i++) begin
      d = vals[i];
      if (d[14:0] > tm) tm = d[14:0];
    end
    run_id++;
    stray_en     = stray;
    bus.start    = 1'b1;
    bus.num_ch   = 16'(req);
    bus.in_valid = 1'b0;
    @(posedge clk);
    e = 0; acc = 0; k = 1 << 20;
    forever begin
      @(negedge clk);
      done_e = (n == 0) ? 1 : k + n + 2;
      gv_exp = (n > 0) && (e >= k + 1) && (e <= k + n);
      n_checks++;
      if (bus.in_ready !== ((n > 0) && (e < k))) begin
        n_fail++; $display("FAIL in_ready e=%0d got %b want %b", e, bus.in_ready, ((n > 0) && (e < k)));
      end
      n_checks++;
      if (bus.gen_valid !== gv_exp) begin
        n_fail++; $display("FAIL gen_valid e=%0d got %b want %b", e, bus.gen_valid, gv_exp);
      end
      n_checks++;
      if (bus.done !== (e == done_e)) begin
        n_fail++; $display("FAIL done e=%0d got %b want %b", e, bus.done, (e == done_e));
      end
      n_checks++;
      if (bus.busy !== ((n > 0) && (e < done_e))) begin
        n_fail++; $display("FAIL busy e=%0d got %b want %b", e, bus.busy, ((n > 0) && (e < done_e)));
      end
      if (gv_exp) begin
        ch = e - k - 1;
        d  = vals[ch];
        n_checks++;
        if (bus.gen_chidx !== 16'(ch)) begin
          n_fail++; $display("FAIL gen_chidx e=%0d got %0d want %0d", e, bus.gen_chidx, ch);
        end
        n_checks++;
        if (bus.gen_data !== {1'b0, d[14:0]}) begin
          n_fail++; $display("FAIL gen_data ch=%0d got %h want %h", ch, bus.gen_data, {1'b0, d[14:0]});
        end
      end
      if (e >= k) begin
        n_checks++;
        if (bus.gen_tmax !== {1'b0, tm}) begin
          n_fail++; $display("FAIL gen_tmax e=%0d got %h want %h", e, bus.gen_tmax, {1'b0, tm});
        end
      end
      if (abort_ch >= 0 && gv_exp && (e - k - 1) == abort_ch) begin
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.gen_valid, bus.busy, bus.done} !== 3'b000) begin
          n_fail++; $display("FAIL abort_outputs got %b want 000", {bus.gen_valid, bus.busy, bus.done});
        end
        n_checks++;
        if ({bus.gen_tmax, bus.max_grp, bus.gen_chidx} !== 40'd0) begin
          n_fail++; $display("FAIL abort_regs got %h/%h/%h want 0", bus.gen_tmax, bus.max_grp, bus.gen_chidx);
        end
        bus.start = 1'b0; bus.in_valid = 1'b0; stray_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        vals.delete(); pat.delete();
        last_k = k; last_done_e = -1;
        return;
      end
      if (e == done_e) begin
        n_checks++;
        if (bus.max_grp !== 8'(gen_max)) begin
          n_fail++; $display("FAIL max_grp got %0d want %0d", bus.max_grp, gen_max);
        end
        break;
      end
      if (e > 600) begin
        n_fail++; n_checks++;
        $display("FAIL timeout e=%0d no done", e);
        break;
      end
      bus.start = mid_start && (e == 2);
      if (mid_start && e == 2) bus.num_ch = 16'd9;
      if (acc < n) begin
        if (pat.size() > 0) v = (pat.pop_front() != 0);
        else v = ($urandom_range(0, 99) >= gap_pct);
        bus.in_valid = v;
        bus.in_data  = v ? vals[acc] : 16'($urandom);
        if (v) begin
          acc++;
          if (acc == n) begin
            k = e + 1;
            stray_en = 1'b0;
          end
        end
      end else begin
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.in_data  = 16'($urandom);
      end
      @(posedge clk);
      e++;
    end
    bus.start = 1'b0; bus.in_valid = 1'b0; stray_en = 1'b0;
    vals.delete(); pat.delete();
    last_k = k; last_done_e = done_e;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; bus.num_ch = '0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.gen_valid, bus.busy, bus.done, bus.in_ready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b want 0000", {bus.gen_valid, bus.busy, bus.done, bus.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.gen_data, bus.gen_chidx, bus.gen_tmax, bus.max_grp} !== 56'd0) begin
      n_fail++; $display("FAIL reset_regs got %h want 0", {bus.gen_data, bus.gen_chidx, bus.gen_tmax, bus.max_grp});
    end
    n_checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle got %b want 00", {bus.busy, bus.done});
    end
  endtask

  task automatic test_basic();
    vals = '{16'h3C00, 16'h4400, 16'h3800, 16'h4000};
    drive_run(4, 0, 1'b0, 1'b0, -1);
    n_checks++;
    if (last_done_e + 1 != 2 * 4 + 3) begin
      n_fail++; $display("FAIL basic_cycles got %0d want %0d", last_done_e + 1, 11);
    end
    n_checks++;
    if (bus.gen_tmax !== 16'h4400) begin
      n_fail++; $display("FAIL basic_tmax got %h want 4400", bus.gen_tmax);
    end
  endtask

  task automatic test_sign_mask();
    vals = '{16'hC800, 16'h4000};
    drive_run(2, 0, 1'b0, 1'b0, -1);
    n_checks++;
    if (bus.gen_tmax !== 16'h4800) begin
      n_fail++; $display("FAIL sign_tmax got %h want 4800", bus.gen_tmax);
    end
  endtask

  task automatic test_stall();
    pat = '{1, 0, 0, 1, 0, 1};
    drive_run(3, 0, 1'b0, 1'b1, -1);
    n_checks++;
    if (last_k != 6) begin
      n_fail++; $display("FAIL stall_last_beat got %0d want 6", last_k);
    end
  endtask

  task automatic test_zero();
    drive_run(0, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_clamp();
    drive_run(200, 0, 1'b0, 1'b0, -1);
    n_checks++;
    if (last_k != 64) begin
      n_fail++; $display("FAIL clamp_beats got %0d want 64", last_k);
    end
  endtask

  task automatic test_abort();
    drive_run(4, 0, 1'b0, 1'b0, 2);
    test_basic();
  endtask

  task automatic test_stray();
    stray_en = 1'b1;
    repeat (3) @(negedge clk);
    drive_run(5, 30, 1'b1, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) drive_run($urandom_range(1, 10), 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      drive_run($urandom_range(0, 80), $urandom_range(0, 50), 1'($urandom_range(0, 1)), 1'b0, -1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_mask();
    test_stall();
    test_zero();
    test_clamp();
    test_abort();
    test_stray();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
